// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel-to-serial frame serializer.
package p2s_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// Saturating up-counter with enable, synchronous clear and a terminal flag at LAST.
module p2s_bit_counter #(
  parameter int W    = 3,
  parameter int LAST = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  assign term = (cnt == W'(LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !term)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/p2s_frame_serializer.sv
// Parallel-to-serial converter: takes a word over valid/ready and shifts it out
// one bit per shift_en strobe, with optional idle gap between words.
module p2s_frame_serializer
  import p2s_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int GAP        = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             flush,
  input  logic             shift_en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             srial_data_out,
  output logic             frame_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             out_nxt, frame_nxt, done_nxt;
  logic             accept;
  logic             bit_clr, bit_en, bit_term;
  logic             gap_clr, gap_en, gap_term;
  logic [BW-1:0]    bit_cnt;
  logic             cnt_unused;

  // The register always holds the bits not yet on the line; head() is the next one out.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  p2s_bit_counter #(
    .W    (BW),
    .LAST (WIDTH - 1)
  ) u_bit_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (bit_clr),
    .en    (bit_en),
    .cnt   (bit_cnt),
    .term  (bit_term)
  );

  assign cnt_unused = ^bit_cnt;

  generate
    if (GAP > 0) begin : g_gap
      logic [GW-1:0] gap_cnt;
      logic          gap_cnt_unused;

      p2s_bit_counter #(
        .W    (GW),
        .LAST (GAP - 1)
      ) u_gap_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (gap_clr),
        .en    (gap_en),
        .cnt   (gap_cnt),
        .term  (gap_term)
      );

      assign gap_cnt_unused = ^gap_cnt;
    end else begin : g_no_gap
      logic ctl_unused;
      assign gap_term   = 1'b1;
      assign ctl_unused = gap_clr ^ gap_en;
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    out_nxt   = srial_data_out;
    frame_nxt = frame_out;
    done_nxt  = 1'b0;
    bit_clr   = 1'b0;
    bit_en    = 1'b0;
    gap_clr   = 1'b0;
    gap_en    = 1'b0;

    // Back-to-back reload is only offered on the strobe that retires the last bit.
    load_ready = !flush && (state == S_IDLE ||
                 (state == S_SHIFT && bit_term && shift_en && GAP == 0));
    accept     = load_valid && load_ready;

    if (flush) begin
      state_nxt = S_IDLE;
      shreg_nxt = '0;
      out_nxt   = IDLE_LEVEL;
      frame_nxt = 1'b0;
      bit_clr   = 1'b1;
      gap_clr   = 1'b1;
    end else if (accept) begin
      state_nxt = S_SHIFT;
      shreg_nxt = advance(data_in);
      out_nxt   = head(data_in);
      frame_nxt = 1'b1;
      bit_clr   = 1'b1;
      done_nxt  = (state == S_SHIFT);
    end else begin
      case (state)
        S_IDLE: ;
        S_SHIFT: begin
          if (shift_en) begin
            if (!bit_term) begin
              shreg_nxt = advance(shreg);
              out_nxt   = head(shreg);
              bit_en    = 1'b1;
            end else begin
              done_nxt  = 1'b1;
              out_nxt   = IDLE_LEVEL;
              frame_nxt = 1'b0;
              if (GAP > 0) begin
                state_nxt = S_GAP;
                gap_clr   = 1'b1;
              end else begin
                state_nxt = S_IDLE;
              end
            end
          end
        end
        S_GAP: begin
          if (shift_en) begin
            gap_en = 1'b1;
            if (gap_term)
              state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shreg          <= '0;
      srial_data_out <= IDLE_LEVEL;
      frame_out      <= 1'b0;
      done           <= 1'b0;
    end else begin
      shreg          <= shreg_nxt;
      srial_data_out <= out_nxt;
      frame_out      <= frame_nxt;
      done           <= done_nxt;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_p2s_frame_serializer.sv
// Self-checking bench: three serializer instances (LSB-first, MSB-first, GAP=2 with idle-high line).
module tb_p2s_frame_serializer;

  typedef struct {
    int         k;
    logic [7:0] word;
    int         period;
    logic [7:0] seq;   // bits in send order, leftmost sent first
  } vec_t;

  localparam logic [2:0] IDLE_L = 3'b100;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [2:0] flush      = '0;
  logic [2:0] shift_en   = '0;
  logic [2:0] load_valid = '0;
  logic [2:0] load_ready, sdo, frame, busy, done;
  logic [7:0] din [3];

  int   checks = 0;
  int   errors = 0;
  int   frame_cycles = 0;
  int   busy_cycles  = 0;
  logic exp_q [$];
  vec_t vecs [10];

  always #5 sys_clk = ~sys_clk;

  p2s_frame_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .GAP(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush[0]), .shift_en(shift_en[0]),
    .load_valid(load_valid[0]), .load_ready(load_ready[0]), .data_in(din[0]),
    .srial_data_out(sdo[0]), .frame_out(frame[0]), .busy(busy[0]), .done(done[0]));

  p2s_frame_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP(0)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush[1]), .shift_en(shift_en[1]),
    .load_valid(load_valid[1]), .load_ready(load_ready[1]), .data_in(din[1]),
    .srial_data_out(sdo[1]), .frame_out(frame[1]), .busy(busy[1]), .done(done[1]));

  p2s_frame_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush[2]), .shift_en(shift_en[2]),
    .load_valid(load_valid[2]), .load_ready(load_ready[2]), .data_in(din[2]),
    .srial_data_out(sdo[2]), .frame_out(frame[2]), .busy(busy[2]), .done(done[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  function automatic logic [7:0] tx_order(input int k, input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return (k == 1) ? w : r;
  endfunction

  task automatic push_seq(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) exp_q.push_back(s[i]);
  endtask

  task automatic load(input int k, input logic [7:0] w, input logic [7:0] s);
    int n = 0;
    while (load_ready[k] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("load_wait", load_ready[k], 1'b1);
    load_valid[k] = 1'b1;
    din[k] = w;
    push_seq(s);
    tick();
    load_valid[k] = 1'b0;
    din[k] = ~w;
  endtask

  task automatic shift_out(input int k, input int p, input int nbits,
                           input bit chain_in, input bit chain_out, input logic [7:0] nw);
    logic b;
    if (chain_out) begin
      load_valid[k] = 1'b1;
      din[k] = nw;
      push_seq(tx_order(k, nw));
    end
    for (int i = 0; i < nbits; i++) begin
      chk("sb_nonempty", exp_q.size() > 0, 1'b1);
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      for (int c = 0; c < p; c++) begin
        shift_en[k] = (c == p - 1);
        #1;
        chk("serial", sdo[k], b);
        chk("frame", frame[k], 1'b1);
        chk("busy", busy[k], 1'b1);
        chk("done", done[k], chain_in && i == 0 && c == 0);
        chk("ready", load_ready[k], k != 2 && i == 7 && c == p - 1);
        if (frame[k] === 1'b1) frame_cycles++;
        if (busy[k] === 1'b1) busy_cycles++;
        tick();
      end
    end
    shift_en[k] = 1'b0;
    if (chain_out) load_valid[k] = 1'b0;
  endtask

  task automatic word_end(input int k);
    #1;
    chk("done_pulse", done[k], 1'b1);
    chk("frame_end", frame[k], 1'b0);
    chk("idle_level", sdo[k], IDLE_L[k]);
    chk("busy_end", busy[k], k == 2);
    chk("ready_end", load_ready[k], k != 2);
    tick();
    chk("done_clear", done[k], 1'b0);
  endtask

  task automatic gap_seq();
    for (int g = 0; g < 2; g++) begin
      chk("gap_level", sdo[2], 1'b1);
      chk("gap_busy", busy[2], 1'b1);
      chk("gap_frame", frame[2], 1'b0);
      shift_en[2] = 1'b1;
      #1;
      chk("gap_ready", load_ready[2], 1'b0);
      tick();
      shift_en[2] = 1'b0;
    end
    #1;
    chk("gap_exit_ready", load_ready[2], 1'b1);
    chk("gap_exit_busy", busy[2], 1'b0);
    chk("gap_exit_done", done[2], 1'b0);
  endtask

  task automatic after_abort(input int k, input string tag);
    chk({tag, "_level"}, sdo[k], IDLE_L[k]);
    chk({tag, "_frame"}, frame[k], 1'b0);
    chk({tag, "_done"}, done[k], 1'b0);
    chk({tag, "_busy"}, busy[k], 1'b0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) din[k] = '0;
    vecs[0] = '{0, 8'hA5, 1, 8'hA5};
    vecs[1] = '{1, 8'hA5, 1, 8'hA5};
    vecs[2] = '{0, 8'h3C, 4, 8'h3C};
    vecs[3] = '{0, 8'h01, 1, 8'h80};
    vecs[4] = '{1, 8'h01, 2, 8'h01};
    vecs[5] = '{0, 8'hC4, 1, 8'h23};
    vecs[6] = '{1, 8'hC4, 3, 8'hC4};
    vecs[7] = '{2, 8'hA5, 1, 8'hA5};
    vecs[8] = '{2, 8'h0E, 2, 8'h70};
    vecs[9] = '{2, 8'h80, 1, 8'h01};

    #1 sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_level", sdo[k], IDLE_L[k]);
      chk("rst_frame", frame[k], 1'b0);
      chk("rst_done", done[k], 1'b0);
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_ready", load_ready[k], 1'b1);
    end
    sys_rst_n = 1'b1;
    tick();

    for (int v = 0; v < 10; v++) begin
      frame_cycles = 0;
      busy_cycles  = 0;
      load(vecs[v].k, vecs[v].word, vecs[v].seq);
      shift_out(vecs[v].k, vecs[v].period, 8, 1'b0, 1'b0, 8'h00);
      chk("frame_cycles", frame_cycles, 8 * vecs[v].period);
      chk("busy_cycles", busy_cycles, 8 * vecs[v].period);
      word_end(vecs[v].k);
      if (vecs[v].k == 2) gap_seq();
    end

    // back-to-back words with load_valid held across the boundary
    frame_cycles = 0;
    load(0, 8'h01, tx_order(0, 8'h01));
    shift_out(0, 1, 8, 1'b0, 1'b1, 8'h80);
    shift_out(0, 1, 8, 1'b1, 1'b0, 8'h00);
    chk("b2b_frame_cycles", frame_cycles, 16);
    word_end(0);

    // flush after three bits, with shift_en and a pending load competing
    load(0, 8'h96, tx_order(0, 8'h96));
    shift_out(0, 1, 3, 1'b0, 1'b0, 8'h00);
    flush[0] = 1'b1; shift_en[0] = 1'b1; load_valid[0] = 1'b1; din[0] = 8'h55;
    #1;
    chk("flush_ready", load_ready[0], 1'b0);
    tick();
    flush[0] = 1'b0; shift_en[0] = 1'b0; load_valid[0] = 1'b0;
    #1;
    after_abort(0, "flush0");
    chk("flush0_ready_after", load_ready[0], 1'b1);
    tick();
    chk("flush0_done_late", done[0], 1'b0);
    load(0, 8'hFF, 8'hFF);
    shift_out(0, 1, 8, 1'b0, 1'b0, 8'h00);
    word_end(0);

    // flush on the last-bit strobe must suppress done
    load(1, 8'h3A, tx_order(1, 8'h3A));
    shift_out(1, 1, 7, 1'b0, 1'b0, 8'h00);
    flush[1] = 1'b1; shift_en[1] = 1'b1;
    tick();
    flush[1] = 1'b0; shift_en[1] = 1'b0;
    #1;
    after_abort(1, "flush1");
    load(1, 8'hFF, 8'hFF);
    shift_out(1, 1, 8, 1'b0, 1'b0, 8'h00);
    word_end(1);

    // asynchronous reset mid-word
    load(2, 8'h69, tx_order(2, 8'h69));
    shift_out(2, 1, 3, 1'b0, 1'b0, 8'h00);
    sys_rst_n = 1'b0;
    #1;
    after_abort(2, "rst_mid");
    tick();
    sys_rst_n = 1'b1;
    tick();
    load(2, 8'hFF, 8'hFF);
    shift_out(2, 2, 8, 1'b0, 1'b0, 8'h00);
    word_end(2);
    gap_seq();

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
